// File: rtl/arm_servo_pwm.sv
// Four-channel hobby-servo PWM generator: 1 us tick prescaler, frame counter, per-channel clamped targets.
// Optional macro ARM_SERVO_SLEW_EN rate-limits each channel's width change to STEP_US per frame.
module arm_servo_pwm #(
    parameter int PRESCALE  = 100,
    parameter int PERIOD_US = 20000,
    parameter int MIN_US    = 500,
    parameter int MAX_US    = 2500,
    parameter int CENTER_US = 1500,
    parameter int STEP_US   = 10
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        enable,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_ch,
    input  logic [15:0] cmd_us,
    output logic [3:0]  pwm,
    output logic        frame_start,
    output logic        busy,
    output logic        clamp_err
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [15:0]   US_LAST    = 16'(PERIOD_US - 1);
    localparam logic [15:0]   MIN_W      = 16'(MIN_US);
    localparam logic [15:0]   MAX_W      = 16'(MAX_US);
    localparam logic [15:0]   CENTER_W   = 16'(CENTER_US);
    localparam logic [15:0]   STEP_W     = 16'(STEP_US);

    logic [PW-1:0] presc_reg;
    logic [15:0]   us_cnt_reg;
    logic          clamp_err_reg;
    logic          xfer;
    logic [15:0]   clamped_us;
    logic          out_of_range;
    logic [3:0]    diff;

    // Counters sit at zero whenever the block is disabled, so re-enabling starts a fresh frame.
    always_ff @(posedge ACLK) begin
        if (ARESET || !enable) begin
            presc_reg  <= '0;
            us_cnt_reg <= '0;
        end else if (presc_reg == PRESC_LAST) begin
            presc_reg  <= '0;
            us_cnt_reg <= (us_cnt_reg == US_LAST) ? 16'd0 : us_cnt_reg + 16'd1;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    assign frame_start = enable && (presc_reg == '0) && (us_cnt_reg == '0);
    assign cmd_ready   = !frame_start;
    assign xfer        = cmd_valid && cmd_ready;

    always_comb begin
        clamped_us   = cmd_us;
        out_of_range = 1'b0;
        if (cmd_us < MIN_W) begin
            clamped_us   = MIN_W;
            out_of_range = 1'b1;
        end else if (cmd_us > MAX_W) begin
            clamped_us   = MAX_W;
            out_of_range = 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            clamp_err_reg <= 1'b0;
        end else if (xfer && out_of_range) begin
            clamp_err_reg <= 1'b1;
        end
    end

    assign clamp_err = clamp_err_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : ch_g
            logic [15:0] target_reg;
            logic [15:0] active_reg;
            logic [15:0] active_next;
            logic        pwm_reg;

`ifdef ARM_SERVO_SLEW_EN
            always_comb begin
                active_next = active_reg;
                if (target_reg > active_reg) begin
                    active_next = ((target_reg - active_reg) > STEP_W) ? active_reg + STEP_W : target_reg;
                end else if (target_reg < active_reg) begin
                    active_next = ((active_reg - target_reg) > STEP_W) ? active_reg - STEP_W : target_reg;
                end
            end
`else
            always_comb begin
                active_next = target_reg;
            end
`endif

            // active only moves at frame_start, so a frame never sees a width change mid-pulse.
            always_ff @(posedge ACLK) begin
                if (ARESET) begin
                    target_reg <= CENTER_W;
                    active_reg <= CENTER_W;
                    pwm_reg    <= 1'b0;
                end else begin
                    if (xfer && (cmd_ch == 2'(gi))) begin
                        target_reg <= clamped_us;
                    end
                    if (frame_start) begin
                        active_reg <= active_next;
                    end
                    pwm_reg <= enable && (us_cnt_reg < active_reg);
                end
            end

            assign pwm[gi]  = pwm_reg;
            assign diff[gi] = (active_reg != target_reg);
        end
    endgenerate

    assign busy = |diff;

endmodule

// File: tb/tb_arm_servo_pwm.sv
// Directed bench for arm_servo_pwm with PRESCALE=2, PERIOD_US=100, MIN=10, MAX=90, CENTER=50, STEP=5.
module tb_arm_servo_pwm;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        enable;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_ch;
    logic [15:0] cmd_us;
    logic [3:0]  pwm;
    logic        frame_start;
    logic        busy;
    logic        clamp_err;

    arm_servo_pwm #(
        .PRESCALE(2), .PERIOD_US(100), .MIN_US(10), .MAX_US(90), .CENTER_US(50), .STEP_US(5)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET), .enable(enable), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ch(cmd_ch), .cmd_us(cmd_us), .pwm(pwm), .frame_start(frame_start), .busy(busy),
        .clamp_err(clamp_err)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [1:0]  ch;
        logic [15:0] us;
        int          w0, w1, w2, w3;
        bit          clamp;
    } vec_t;

    vec_t vecs [5];
    int   total = 0;
    int   bad   = 0;
    int   widths [4];
    int   prev_w [4];
    int   exp_w  [4];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Waits (bounded) for a frame_start, then counts pwm-high cycles over the following 200 cycles.
    task automatic measure();
        int guard = 0;
        int fs_err = 0;
        while (!frame_start && guard < 500) begin
            @(negedge ACLK);
            guard++;
        end
        check("frame_start_seen", int'(frame_start), 1);
        for (int c = 0; c < 4; c++) widths[c] = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge ACLK);
            for (int c = 0; c < 4; c++) widths[c] += int'(pwm[c]);
            if (i < 200 && frame_start) fs_err++;
        end
        check("frame_period_200", int'(fs_err == 0 && frame_start), 1);
    endtask

    task automatic send_cmd(input logic [1:0] ch, input logic [15:0] us);
        bit done = 1'b0;
        int guard = 0;
        while (!done && guard < 10) begin
            @(negedge ACLK);
            cmd_valid = 1'b1;
            cmd_ch    = ch;
            cmd_us    = us;
            done      = cmd_ready;
            guard++;
            @(posedge ACLK);
        end
        #1;
        cmd_valid = 1'b0;
        if (!done) check("cmd_accept_timeout", 0, 1);
    endtask

    task automatic check_widths(input string tag);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("%s_w%0d", tag, c), widths[c], exp_w[c] * 2);
        end
    endtask

    initial begin
        vecs[0] = '{ch: 2'd1, us: 16'd60,  w0: 50, w1: 60, w2: 50, w3: 50, clamp: 1'b0};
        vecs[1] = '{ch: 2'd2, us: 16'd200, w0: 50, w1: 60, w2: 90, w3: 50, clamp: 1'b1};
        vecs[2] = '{ch: 2'd2, us: 16'd5,   w0: 50, w1: 60, w2: 10, w3: 50, clamp: 1'b1};
        vecs[3] = '{ch: 2'd0, us: 16'd10,  w0: 10, w1: 60, w2: 10, w3: 50, clamp: 1'b1};
        vecs[4] = '{ch: 2'd3, us: 16'd90,  w0: 10, w1: 60, w2: 10, w3: 90, clamp: 1'b1};

        ARESET = 1'b1; enable = 1'b0; cmd_valid = 1'b0; cmd_ch = 2'd0; cmd_us = 16'd0;
        repeat (3) @(negedge ACLK);
        check("rst_pwm", int'(pwm), 0);
        check("rst_clamp_err", int'(clamp_err), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_start", int'(frame_start), 0);

        ARESET = 1'b0; enable = 1'b1;
        #1;
        check("first_enable_frame_start", int'(frame_start), 1);
        for (int c = 0; c < 4; c++) exp_w[c] = 50;
        measure();
        check_widths("center");
        check("center_busy", int'(busy), 0);

`ifdef ARM_SERVO_SLEW_EN
        send_cmd(2'd1, 16'd60);
        measure();
        check("slew1_w1", widths[1], 110);
        check("slew1_busy", int'(busy), 1);
        measure();
        check("slew2_w1", widths[1], 120);
        check("slew2_busy", int'(busy), 0);
`endif

        for (int c = 0; c < 4; c++) prev_w[c] = 50;
`ifdef ARM_SERVO_SLEW_EN
        prev_w[1] = 60;
`endif
        for (int v = 0; v < 5; v++) begin
            exp_w[0] = vecs[v].w0; exp_w[1] = vecs[v].w1;
            exp_w[2] = vecs[v].w2; exp_w[3] = vecs[v].w3;
            send_cmd(vecs[v].ch, vecs[v].us);
            @(negedge ACLK);
            check($sformatf("v%0d_busy_after_cmd", v), int'(busy),
                  int'(exp_w[vecs[v].ch] != prev_w[vecs[v].ch]));
            check($sformatf("v%0d_clamp_err", v), int'(clamp_err), int'(vecs[v].clamp));
`ifdef ARM_SERVO_SLEW_EN
            for (int f = 0; f < 17; f++) measure();
`else
            measure();
`endif
            check_widths($sformatf("v%0d", v));
            check($sformatf("v%0d_busy_settled", v), int'(busy), 0);
            for (int c = 0; c < 4; c++) prev_w[c] = exp_w[c];
        end

        // Command held across a frame_start: refused on that cycle, accepted the next.
        repeat (200) @(negedge ACLK);
        check("hold_fs_now", int'(frame_start), 1);
        check("hold_ready_low", int'(cmd_ready), 0);
        cmd_valid = 1'b1; cmd_ch = 2'd0; cmd_us = 16'd30;
        @(negedge ACLK);
        check("hold_ready_high", int'(cmd_ready), 1);
        check("hold_busy_before", int'(busy), 0);
        @(negedge ACLK);
        cmd_valid = 1'b0;
        check("hold_busy_after", int'(busy), 1);
        exp_w[0] = 30;
`ifdef ARM_SERVO_SLEW_EN
        for (int f = 0; f < 17; f++) measure();
`else
        measure();
`endif
        check_widths("hold");

        // Enable dropped mid-pulse, then restored.
        repeat (10) @(negedge ACLK);
        check("mid_pulse_pwm", int'(pwm), 15);
        enable = 1'b0;
        @(negedge ACLK);
        check("disable_pwm", int'(pwm), 0);
        repeat (5) @(negedge ACLK);
        check("disabled_pwm_hold", int'(pwm), 0);
        check("disabled_fs", int'(frame_start), 0);
        enable = 1'b1;
        #1;
        check("reenable_fs", int'(frame_start), 1);
        measure();
        check_widths("reenable");

        // Reset mid-frame with a command presented during reset.
        repeat (20) @(negedge ACLK);
        ARESET = 1'b1; cmd_valid = 1'b1; cmd_ch = 2'd1; cmd_us = 16'd80;
        @(negedge ACLK);
        check("midrst_pwm", int'(pwm), 0);
        check("midrst_clamp_err", int'(clamp_err), 0);
        @(negedge ACLK);
        ARESET = 1'b0; cmd_valid = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        for (int c = 0; c < 4; c++) exp_w[c] = 50;
        measure();
        check_widths("midrst");

        // Exactly-at-limit commands must not raise clamp_err.
        send_cmd(2'd3, 16'd90);
        send_cmd(2'd0, 16'd10);
        @(negedge ACLK);
        check("limits_no_clamp", int'(clamp_err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
